dwt2d_scheduler: RTL and testbench

Sequences a single-level 2-D wavelet transform of a LENGTH×LENGTH 8-bit tile through the shared 1-D transform core, whose output is the coefs_to_row S-then-D row stream. It runs a row pass, then a column pass, over an in-place tile memory. For each line it reads LENGTH samples, streams them into the core, and writes the core's LENGTH results back to the same line positions. It sits between the tile RAM and the 1-D core and is the only master of both.

---
 rtl/dwt2d_scheduler_pkg.sv | 22 ++
 rtl/dwt2d_addr_gen.sv | 17 +
 rtl/dwt2d_scheduler.sv | 167 ++++++++++++++++
 tb/tb_dwt2d_scheduler.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwt2d_scheduler_pkg.sv
// Shared constants and types for the 2-D wavelet scheduler.
// Tile geometry, address width helper and FSM state encoding.
package dwt2d_scheduler_pkg;

    localparam int LENGTH = 8;
    localparam int LW = $clog2(LENGTH);

    function automatic int addr_w(input int len);
        return $clog2(len * len);
    endfunction

    localparam int ADDR_W = addr_w(LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/dwt2d_addr_gen.sv
// Maps (pass, line, index) to a tile RAM address.
// Row pass walks along a row, column pass walks down a column.
module dwt2d_addr_gen
    import dwt2d_scheduler_pkg::*;
(
    input  logic              pass,
    input  logic [LW-1:0]     line,
    input  logic [LW-1:0]     k,
    output logic [ADDR_W-1:0] addr
);

    // Multiplying by LENGTH is a concatenation since LENGTH is a power of two
    always_comb begin
        addr = pass ? {k, line} : {line, k};
    end

endmodule

// File: rtl/dwt2d_scheduler.sv
// Drives row then column passes of an in-place tile through the 1-D core.
// Reads a line, streams it to the core, writes results back in place.
module dwt2d_scheduler
    import dwt2d_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              pass,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic              core_en,
    output logic              core_valid,
    output logic [7:0]        core_in,
    input  logic              core_result,
    input  logic [7:0]        core_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LAST = LW'(LENGTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t state, state_nxt;

    logic [LW-1:0]     line;
    logic [LW-1:0]     k_rd;
    logic [LW-1:0]     k_wr;
    logic [TW-1:0]     tmo;
    logic              accept;
    logic              tmo_hit;
    logic              go;
    logic [ADDR_W-1:0] wr_addr;

    dwt2d_addr_gen u_rd_addr (
        .pass (pass),
        .line (line),
        .k    (k_rd),
        .addr (mem_rd_addr)
    );

    dwt2d_addr_gen u_wr_addr (
        .pass (pass),
        .line (line),
        .k    (k_wr),
        .addr (wr_addr)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and result acceptance
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo_hit   = 1'b0;
        go        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                accept = core_result;
                if (k_rd == LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                accept  = core_result;
                tmo_hit = !core_result && (tmo == TMO_LAST);
                if (core_result && k_wr == LAST) state_nxt = S_NEXT;
                else if (tmo_hit)                state_nxt = S_IDLE;
            end
            S_NEXT: begin
                if (line != LAST || !pass) state_nxt = S_FEED;
                else                       state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status and read strobe follow the state directly
    always_comb begin
        busy      = (state == S_FEED) || (state == S_DRAIN) || (state == S_NEXT);
        done      = (state == S_DONE);
        mem_rd_en = (state == S_FEED);
        core_in   = core_valid ? mem_rd_data : 8'd0;
    end

    // Line, index, timeout counters and sticky error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line  <= '0;
            pass  <= 1'b0;
            k_rd  <= '0;
            k_wr  <= '0;
            tmo   <= '0;
            error <= 1'b0;
        end else begin
            if (go) begin
                line  <= '0;
                pass  <= 1'b0;
                k_rd  <= '0;
                k_wr  <= '0;
                tmo   <= '0;
                error <= 1'b0;
            end
            if (state == S_FEED) k_rd <= k_rd + 1'b1;
            if (accept)          k_wr <= k_wr + 1'b1;
            if (state == S_DRAIN) begin
                tmo <= core_result ? '0 : tmo + 1'b1;
            end
            if (tmo_hit) error <= 1'b1;
            if (state == S_NEXT) begin
                k_rd <= '0;
                k_wr <= '0;
                tmo  <= '0;
                if (line != LAST) begin
                    line <= line + 1'b1;
                end else begin
                    line <= '0;
                    pass <= 1'b1;
                end
            end
        end
    end

    // Registered write-back of accepted core results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= accept;
            if (accept) begin
                mem_wr_addr <= wr_addr;
                mem_wr_data <= core_out;
            end
        end
    end

    // Core stream is the read strobe delayed by the RAM latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_valid <= 1'b0;
            core_en    <= 1'b0;
        end else begin
            core_valid <= mem_rd_en;
            core_en    <= mem_rd_en && (k_rd == '0);
        end
    end

endmodule

// File: tb/tb_dwt2d_scheduler.sv
// Directed bench for dwt2d_scheduler with a RAM model and a 1-D core model.
// Core model adds a constant, can insert gaps, or stall a chosen line.
module tb_dwt2d_scheduler;
    import dwt2d_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        busy, done, error, pass;
    logic        mem_rd_en, mem_wr_en;
    logic [5:0]  mem_rd_addr, mem_wr_addr;
    logic [7:0]  mem_rd_data, mem_wr_data;
    logic        core_en, core_valid, core_result;
    logic [7:0]  core_in, core_out;

    dwt2d_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pass        (pass),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .core_en     (core_en),
        .core_valid  (core_valid),
        .core_in     (core_in),
        .core_result (core_result),
        .core_out    (core_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // RAM model, one-cycle read latency
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    // Core model
    typedef struct {
        logic [7:0] d;
        int         t;
    } ent_t;
    ent_t cq[$];
    int inc = 0;
    int gap = 0;
    int kill_line = -1;
    int cyc = 0;
    int en_cnt = 0;
    int gap_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) begin
            cq.delete();
            core_result <= 1'b0;
            core_out    <= 8'd0;
            en_cnt  = 0;
            gap_cnt = 0;
        end else begin
            if (core_en) en_cnt = en_cnt + 1;
            if (core_valid && !(kill_line >= 0 && en_cnt - 1 == kill_line))
                cq.push_back('{d: 8'(int'(core_in) + inc), t: cyc});
            core_result <= 1'b0;
            if (cq.size() > 0 && cyc - cq[0].t >= 2 && gap_cnt == 0) begin
                core_result <= 1'b1;
                core_out    <= cq[0].d;
                void'(cq.pop_front());
                gap_cnt = gap;
            end else if (gap_cnt > 0) begin
                gap_cnt = gap_cnt - 1;
            end
        end
    end

    // Bus monitor, sampled on the falling edge
    int   rd_q[$];
    int   wr_q[$];
    int   ncyc = 0, last_rd = 0, fall_cyc = 0;
    int   done_cnt = 0, done_busy = 0, next_cnt = 0, wr_all = 0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (resetn) begin
            if (mem_rd_en) begin
                rd_q.push_back(int'(mem_rd_addr));
                last_rd = ncyc;
            end
            if (mem_wr_en) wr_q.push_back(int'(mem_wr_addr));
            if (done) done_cnt = done_cnt + 1;
            if (done && busy) done_busy = done_busy + 1;
            if (busy_q && !busy) fall_cyc = ncyc;
            if (dut.state == S_NEXT) next_cnt = next_cnt + 1;
        end
        if (mem_wr_en) wr_all = wr_all + 1;
        busy_q = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        done_cnt  = 0;
        done_busy = 0;
        next_cnt  = 0;
        fall_cyc  = 0;
    endtask

    task automatic do_reset();
        start  = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic init_tile(input int x);
        for (int i = 0; i < 64; i++) mem[i] = 8'(i ^ x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int exp_addr(input int i);
        int j;
        if (i < 64) return i;
        j = i - 64;
        return (j % 8) * 8 + (j / 8);
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({busy, done, error, pass} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_status got %b want 0000", {busy, done, error, pass});
        end
        n_cmp++;
        if ({mem_rd_en, mem_wr_en, core_en, core_valid} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got %b want 0000",
                     {mem_rd_en, mem_wr_en, core_en, core_valid});
        end
        n_cmp++;
        if ({mem_rd_addr, mem_wr_addr, mem_wr_data, core_in} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_buses got %h want 0",
                     {mem_rd_addr, mem_wr_addr, mem_wr_data, core_in});
        end
    endtask

    task automatic test_echo();
        bit ok;
        int bad;
        do_reset();
        inc = 0; gap = 0; kill_line = -1;
        init_tile(8'h5A);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, mem_rd_en, mem_rd_addr, core_valid} !== {1'b1, 1'b1, 6'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL start_t1 got busy=%b rd=%b addr=%0d cv=%b want 1 1 0 0",
                     busy, mem_rd_en, mem_rd_addr, core_valid);
        end
        tick();
        n_cmp++;
        if ({core_en, core_valid, core_in} !== {1'b1, 1'b1, 8'h5A}) begin
            n_bad++;
            $display("FAIL start_t2 got en=%b cv=%b in=%h want 1 1 5a",
                     core_en, core_valid, core_in);
        end
        tick();
        n_cmp++;
        if ({core_en, core_valid, core_in} !== {1'b0, 1'b1, 8'h5B}) begin
            n_bad++;
            $display("FAIL start_t3 got en=%b cv=%b in=%h want 0 1 5b",
                     core_en, core_valid, core_in);
        end
        wait_done(3000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL echo_done got timeout want done");
        end
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (i >= rd_q.size() || rd_q[i] != exp_addr(i)) bad++;
        n_cmp++;
        if (rd_q.size() != 128 || bad != 0) begin
            n_bad++;
            $display("FAIL echo_rd_addrs got n=%0d bad=%0d want n=128 bad=0", rd_q.size(), bad);
        end
        n_cmp++;
        if (done_cnt != 1 || done_busy != 0) begin
            n_bad++;
            $display("FAIL echo_done_pulse got cnt=%0d with_busy=%0d want 1 0",
                     done_cnt, done_busy);
        end
    endtask

    task automatic test_transform();
        bit ok;
        int bad;
        do_reset();
        inc = 1; gap = 0; kill_line = -1;
        init_tile(0);
        pulse_start();
        wait_done(3000, ok);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== 8'(i + 2)) bad++;
        n_cmp++;
        if (!ok || bad != 0) begin
            n_bad++;
            $display("FAIL transform_tile got done=%b bad_words=%0d want 1 0", ok, bad);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        int bad;
        do_reset();
        inc = 1; gap = 2; kill_line = -1;
        init_tile(0);
        pulse_start();
        wait_done(5000, ok);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (i >= wr_q.size() || wr_q[i] != exp_addr(i)) bad++;
        n_cmp++;
        if (!ok || wr_q.size() != 128 || bad != 0) begin
            n_bad++;
            $display("FAIL gaps_wr_addrs got done=%b n=%0d bad=%0d want 1 128 0",
                     ok, wr_q.size(), bad);
        end
        n_cmp++;
        if (next_cnt != 16) begin
            n_bad++;
            $display("FAIL gaps_next_cycles got %0d want 16", next_cnt);
        end
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== 8'(i + 2)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL gaps_tile got bad_words=%0d want 0", bad);
        end
        gap = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        inc = 0; gap = 0; kill_line = 3;
        init_tile(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        n_cmp++;
        if (!ok || error !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_abort got idle=%b error=%b busy=%b want 1 1 0", ok, error, busy);
        end
        n_cmp++;
        if (fall_cyc - last_rd != 65) begin
            n_bad++;
            $display("FAIL tmo_latency got %0d want 65", fall_cyc - last_rd);
        end
        n_cmp++;
        if (done_cnt != 0 || wr_q.size() != 24 || rd_q.size() != 32) begin
            n_bad++;
            $display("FAIL tmo_traffic got done=%0d wr=%0d rd=%0d want 0 24 32",
                     done_cnt, wr_q.size(), rd_q.size());
        end
        kill_line = -1;
        clear_logs();
        pulse_start();
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_clear got error=%b busy=%b want 0 1", error, busy);
        end
        wait_done(3000, ok);
        n_cmp++;
        if (!ok || error !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_rerun got done=%b error=%b want 1 0", ok, error);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        inc = 0; gap = 0; kill_line = -1;
        init_tile(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start = (i % 3 == 0);
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (!ok || done_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done got seen=%b cnt=%0d busy=%b want 1 1 0", ok, done_cnt, busy);
        end
        n_cmp++;
        if (rd_q.size() != 128 || wr_q.size() != 128) begin
            n_bad++;
            $display("FAIL b2b_traffic got rd=%0d wr=%0d want 128 128", rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int wr_before;
        int bad;
        do_reset();
        inc = 0; gap = 0; kill_line = -1;
        init_tile(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (pass) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (20) tick();
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (!ok || {busy, done, error, pass, mem_rd_en, mem_wr_en, core_en, core_valid} !== 8'd0
            || {mem_rd_addr, mem_wr_addr, mem_wr_data, core_in} !== 28'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got col=%b st=%b bus=%h want 1 0 0", ok,
                     {busy, done, error, pass, mem_rd_en, mem_wr_en, core_en, core_valid},
                     {mem_rd_addr, mem_wr_addr, mem_wr_data, core_in});
        end
        wr_before = wr_all;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (wr_all != wr_before) begin
            n_bad++;
            $display("FAIL rstmid_no_write got %0d want 0", wr_all - wr_before);
        end
        clear_logs();
        inc = 1;
        init_tile(0);
        pulse_start();
        wait_done(3000, ok);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== 8'(i + 2)) bad++;
        n_cmp++;
        if (!ok || done_cnt != 1 || bad != 0) begin
            n_bad++;
            $display("FAIL rstmid_rerun got done=%b cnt=%0d bad=%0d want 1 1 0",
                     ok, done_cnt, bad);
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        test_reset();
        test_echo();
        test_transform();
        test_gaps();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
